pedestre_request: RTL and testbench
===================================

# pedestre_request

Pedestrian push-button front end for the traffic light controller. Synchronises and debounces the raw crossing button, then latches a single crossing request. Drives the controller's `pedestre` input until the pedestrian phase is served, then ignores further presses for a hold-off window so one crossing cannot be re-requested immediately.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops on `botao`; legal range is 2 or more.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive identical synchronised samples required before the filtered level changes; legal range is 1–15.
- `HOLDOFF_CYCLES`, default 8: number of cycles after service during which presses are discarded; legal range is 1–255.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `botao`  in  1  raw, asynchronous, bouncing button level (1 = pressed).
- `atendido`  in  1  controller's pedestrian-green indication (`pedestre_verde`).
- `pedestre`  out  1  latched crossing request to the controller.
- `bloqueado`  out  1  high while presses are being discarded (SERVING or HOLDOFF).
- `pedidos`  out  8  saturating count of accepted requests.

## Operation
- Reset (synchronous, while `reset`=1 at a clock edge):
  - Synchroniser flops, filtered level, debounce counter and hold-off counter all cleared.
  - State goes to IDLE.
  - `pedestre`=0, `bloqueado`=0, `pedidos`=0.
  - Reset mid-operation discards any pending request. `pedestre` is low on the first edge after reset.
- Debounce:
  - The counter increments each cycle that the synchroniser output differs from the filtered level. It clears to 0 whenever the two are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`, the filtered level toggles and the counter clears on the same edge.
  - A bounce shorter than `DEBOUNCE_CYCLES` samples produces no change.
- Press event: a single-cycle pulse generated on a registered rising edge of the filtered level. Release generates nothing.
- FSM:
  - IDLE: a press moves to PENDING and increments `pedidos` (saturates at 255). `atendido` is ignored.
  - PENDING: `pedestre`=1. Further presses are absorbed (no count). When `atendido`=1, move to SERVING.
  - SERVING: `pedestre`=0, `bloqueado`=1. Presses are discarded. When `atendido`=0, load the hold-off counter with `HOLDOFF_CYCLES`-1 and move to HOLDOFF.
  - HOLDOFF: `bloqueado`=1. Presses are discarded. The counter decrements each cycle; when it reaches 0, move to IDLE.
- Simultaneous events:
  - Press and `atendido` in the same IDLE cycle: the press is accepted (go to PENDING). `atendido` is evaluated again in PENDING on the next cycle.
  - The button is still held down when the FSM returns to IDLE: no new event, because a fresh rising edge of the filtered level is required.
- All outputs are registered; there is no combinational path from any input to any output.

## Timing
- `botao` held high from the first edge at which it is sampled high: `pedestre` rises after exactly `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1 edges (7 with defaults).
- `atendido` rising in PENDING: `pedestre` falls and `bloqueado` rises on the next edge (1-cycle latency).
- `atendido` falling in SERVING: HOLDOFF is entered on the next edge. IDLE is reached after `HOLDOFF_CYCLES` further edges; `bloqueado` is low from that edge on.
- The controller samples `pedestre` only when its street-2 yellow phase expires. Holding the request level across any number of cycles is therefore required.
- `pedidos` updates on the same edge that PENDING is entered.

## Structure
- Shared package `semaforo_pkg`:
  - `ped_state_t` enum (IDLE, PENDING, SERVING, HOLDOFF), 2-bit encoding.
  - Default constants for `SYNC_STAGES`, `DEBOUNCE_CYCLES` and `HOLDOFF_CYCLES`, so the controller and the bench share the same values.
- Sub-module `debouncer`: synchroniser plus debounce counter, parameterised by `SYNC_STAGES` and `DEBOUNCE_CYCLES`, with output filtered level. It is reused later for other panel inputs.
- Top level: edge detect, FSM, hold-off counter, request counter.

## Test plan
- Clean press: `botao` held high from cycle 0 → `pedestre`=1 from edge 7, `pedidos`=1.
- Bounce: `botao` high for 3 cycles, low for 2, high for 3, then low → `pedestre` stays 0, `pedidos`=0.
- Service handshake: from PENDING, `atendido`=1 for 5 cycles then 0 → `pedestre` falls 1 edge after `atendido` rises. `bloqueado`=1 until 8 edges after `atendido` falls, then 0.
- Discard window: a clean press during SERVING and another during HOLDOFF → no PENDING entry and `pedidos` unchanged. A press released and re-pressed after IDLE → accepted.
- Simultaneous/reset: press event coincident with `atendido`=1 in IDLE → PENDING, then SERVING next cycle. `reset` asserted in PENDING → `pedestre`=0 and `pedidos`=0 on the next edge.
- Saturation: 260 separated clean press/service cycles → `pedidos` stops at 255.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared types and default timing constants for the traffic light controller
// and its pedestrian front end.
package semaforo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2,
        HOLDOFF = 2'd3
    } ped_state_t;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned HOLDOFF_CYCLES_DEF  = 8;

    localparam int unsigned DEB_CNT_W  = 4;
    localparam int unsigned HOLD_CNT_W = 8;
    localparam int unsigned PEDIDOS_W  = 8;

endpackage

// File: rtl/debouncer.sv
// Synchroniser chain plus consecutive-sample debounce filter for a raw panel input.
module debouncer
    import semaforo_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic filtered
);

    logic [SYNC_STAGES-1:0] sync;
    logic [DEB_CNT_W-1:0]   cnt;
    logic                   sync_out;

    assign sync_out = sync[SYNC_STAGES-1];

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync     <= '0;
            cnt      <= '0;
            filtered <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (sync_out == filtered) begin
                cnt <= '0;
            end else if (cnt == DEB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filtered <= ~filtered;
                cnt      <= '0;
            end else begin
                cnt <= cnt + DEB_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pedestre_request.sv
// Pedestrian push-button front end: debounced press latches one crossing request,
// held until served, followed by a hold-off window that discards presses.
module pedestre_request
    import semaforo_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 botao,
    input  logic                 atendido,
    output logic                 pedestre,
    output logic                 bloqueado,
    output logic [PEDIDOS_W-1:0] pedidos
);

    ped_state_t            state, state_next;
    logic [HOLD_CNT_W-1:0] hold_cnt, hold_cnt_next;
    logic [PEDIDOS_W-1:0]  pedidos_next;
    logic                  filtered, filtered_q;
    logic                  press_c;

    debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .reset    (reset),
        .din      (botao),
        .filtered (filtered)
    );

    assign press_c = filtered & ~filtered_q;

    // Next-state, hold-off and request-count logic.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        pedidos_next  = pedidos;
        case (state)
            IDLE: begin
                if (press_c) begin
                    state_next = PENDING;
                    if (pedidos != '1) begin
                        pedidos_next = pedidos + PEDIDOS_W'(1);
                    end
                end
            end
            PENDING: begin
                if (atendido) begin
                    state_next = SERVING;
                end
            end
            SERVING: begin
                if (!atendido) begin
                    hold_cnt_next = HOLD_CNT_W'(HOLDOFF_CYCLES - 1);
                    state_next    = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (hold_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt - HOLD_CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land on the transition edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            pedidos    <= '0;
            filtered_q <= 1'b0;
            pedestre   <= 1'b0;
            bloqueado  <= 1'b0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_cnt_next;
            pedidos    <= pedidos_next;
            filtered_q <= filtered;
            pedestre   <= (state_next == PENDING);
            bloqueado  <= (state_next == SERVING) || (state_next == HOLDOFF);
        end
    end

endmodule

// File: tb/tb_pedestre_request.sv
// Directed self-checking bench for pedestre_request with default parameters.
module tb_pedestre_request;
    import semaforo_pkg::*;

    logic       clk;
    logic       reset;
    logic       botao;
    logic       atendido;
    logic       pedestre;
    logic       bloqueado;
    logic [7:0] pedidos;

    int n_checks = 0;
    int n_fail   = 0;

    pedestre_request dut (
        .clk       (clk),
        .reset     (reset),
        .botao     (botao),
        .atendido  (atendido),
        .pedestre  (pedestre),
        .bloqueado (bloqueado),
        .pedidos   (pedidos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        botao    = 1'b0;
        atendido = 1'b0;
        cyc(2);
        check("rst_pedestre", int'(pedestre), 0);
        check("rst_bloqueado", int'(bloqueado), 0);
        check("rst_pedidos", int'(pedidos), 0);
        reset = 1'b0;
        cyc(1);

        // Clean press: request appears on the 7th edge
        botao = 1'b1;
        cyc(6);
        check("press_edge6_pedestre", int'(pedestre), 0);
        cyc(1);
        check("press_edge7_pedestre", int'(pedestre), 1);
        check("press_pedidos", int'(pedidos), 1);
        check("press_bloqueado", int'(bloqueado), 0);

        // Second press while pending is absorbed
        botao = 1'b0;
        cyc(10);
        botao = 1'b1;
        cyc(10);
        check("absorb_pedestre", int'(pedestre), 1);
        check("absorb_pedidos", int'(pedidos), 1);
        botao = 1'b0;
        cyc(8);

        // Service handshake and hold-off window
        atendido = 1'b1;
        cyc(1);
        check("serve_pedestre", int'(pedestre), 0);
        check("serve_bloqueado", int'(bloqueado), 1);
        cyc(4);
        atendido = 1'b0;
        cyc(1);
        check("holdoff_enter_bloqueado", int'(bloqueado), 1);
        cyc(7);
        check("holdoff_last_bloqueado", int'(bloqueado), 1);
        cyc(1);
        check("holdoff_done_bloqueado", int'(bloqueado), 0);
        check("holdoff_done_pedestre", int'(pedestre), 0);
        check("holdoff_done_pedidos", int'(pedidos), 1);

        // Bounce shorter than the debounce window
        botao = 1'b1;
        cyc(3);
        botao = 1'b0;
        cyc(2);
        botao = 1'b1;
        cyc(3);
        botao = 1'b0;
        cyc(10);
        check("bounce_pedestre", int'(pedestre), 0);
        check("bounce_pedidos", int'(pedidos), 1);

        // Discard window: presses during SERVING and HOLDOFF
        botao = 1'b1;
        cyc(8);
        check("disc_req_pedestre", int'(pedestre), 1);
        check("disc_req_pedidos", int'(pedidos), 2);
        botao = 1'b0;
        cyc(8);
        atendido = 1'b1;
        cyc(1);
        botao = 1'b1;
        cyc(8);
        check("disc_serving_pedestre", int'(pedestre), 0);
        check("disc_serving_bloqueado", int'(bloqueado), 1);
        check("disc_serving_pedidos", int'(pedidos), 2);
        botao = 1'b0;
        cyc(8);
        atendido = 1'b0;
        botao    = 1'b1;
        cyc(1);
        cyc(7);
        check("disc_holdoff_bloqueado", int'(bloqueado), 1);
        check("disc_holdoff_pedestre", int'(pedestre), 0);
        cyc(1);
        check("disc_idle_bloqueado", int'(bloqueado), 0);
        cyc(5);
        check("held_no_event_pedestre", int'(pedestre), 0);
        check("held_no_event_pedidos", int'(pedidos), 2);

        // Release and re-press after IDLE is accepted
        botao = 1'b0;
        cyc(8);
        botao = 1'b1;
        cyc(7);
        check("repress_pedestre", int'(pedestre), 1);
        check("repress_pedidos", int'(pedidos), 3);
        botao    = 1'b0;
        atendido = 1'b1;
        cyc(2);
        atendido = 1'b0;
        cyc(10);
        check("repress_done_bloqueado", int'(bloqueado), 0);

        // Press coincident with atendido in IDLE
        botao    = 1'b1;
        atendido = 1'b1;
        cyc(7);
        check("simul_pedestre", int'(pedestre), 1);
        check("simul_pedidos", int'(pedidos), 4);
        check("simul_bloqueado", int'(bloqueado), 0);
        cyc(1);
        check("simul_next_pedestre", int'(pedestre), 0);
        check("simul_next_bloqueado", int'(bloqueado), 1);
        atendido = 1'b0;
        botao    = 1'b0;
        cyc(10);
        check("simul_done_bloqueado", int'(bloqueado), 0);

        // Reset while PENDING
        botao = 1'b1;
        cyc(7);
        check("prerst_pedestre", int'(pedestre), 1);
        check("prerst_pedidos", int'(pedidos), 5);
        reset = 1'b1;
        botao = 1'b0;
        cyc(1);
        check("midrst_pedestre", int'(pedestre), 0);
        check("midrst_pedidos", int'(pedidos), 0);
        check("midrst_bloqueado", int'(bloqueado), 0);
        reset = 1'b0;
        cyc(10);
        check("postrst_pedestre", int'(pedestre), 0);

        // Saturation of the request counter
        for (int i = 0; i < 260; i++) begin
            botao = 1'b1;
            cyc(7);
            check("sat_pedestre", int'(pedestre), 1);
            if (i == 0) check("sat_first_pedidos", int'(pedidos), 1);
            if (i == 254) check("sat_255_pedidos", int'(pedidos), 255);
            botao    = 1'b0;
            atendido = 1'b1;
            cyc(1);
            atendido = 1'b0;
            cyc(10);
        end
        check("sat_final_pedidos", int'(pedidos), 255);
        check("sat_final_bloqueado", int'(bloqueado), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
